// File: rtl/systolic_feeder_if.sv
// Handshake and array-control bundle between an upstream tile source and the
// systolic feeder; the feeder takes the slave side.
interface systolic_feeder_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int KW    = 16
);
  logic               start;
  logic [KW-1:0]      k_len;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic [N*WIDTH-1:0] in_weight;
  logic [N*WIDTH-1:0] data_out;
  logic [N*WIDTH-1:0] weight_out;
  logic               pe_clear;
  logic               pe_load;
  logic               busy;
  logic               done;

  modport master (
    output start, k_len, in_valid, in_data, in_weight,
    input  in_ready, data_out, weight_out, pe_clear, pe_load, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, in_data, in_weight,
    output in_ready, data_out, weight_out, pe_clear, pe_load, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Input sequencer for an NxN systolic array: skews lane i by i cycles, drives
// the broadcast clear/load controls and flushes zeros before signalling done.
module systolic_feeder #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int KW    = 16
) (
  input  logic              clock,
  input  logic              reset,
  systolic_feeder_if.slave  bus
);

  localparam int FW = $clog2(2 * N);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t        r_state;
  logic [KW-1:0] r_k_len;
  logic [KW-1:0] r_beat_cnt;
  logic [FW-1:0] r_flush_cnt;

  logic w_accept;
  logic w_skew_clr;

  assign w_accept   = bus.in_valid && (r_state == ST_STREAM);
  assign w_skew_clr = (r_state == ST_CLEAR);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_k_len    <= bus.k_len;
            r_beat_cnt <= '0;
            r_state    <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_flush_cnt <= '0;
          r_state     <= (r_k_len == '0) ? ST_DONE : ST_STREAM;
        end
        ST_STREAM: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + KW'(1);
            if (r_beat_cnt + KW'(1) == r_k_len) begin
              r_flush_cnt <= '0;
              r_state     <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == FLUSH_LAST) begin
            r_state <= ST_DONE;
          end else begin
            r_flush_cnt <= r_flush_cnt + FW'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Lane gi: gi delay stages followed by the shared output register stage.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [WIDTH-1:0] w_d_in;
      logic [WIDTH-1:0] w_w_in;
      logic [WIDTH-1:0] r_d_out;
      logic [WIDTH-1:0] r_w_out;

      assign w_d_in = w_accept ? bus.in_data[gi*WIDTH +: WIDTH]   : '0;
      assign w_w_in = w_accept ? bus.in_weight[gi*WIDTH +: WIDTH] : '0;

      if (gi == 0) begin : g_direct
        always_ff @(posedge clock) begin
          if (reset || w_skew_clr) begin
            r_d_out <= '0;
            r_w_out <= '0;
          end else begin
            r_d_out <= w_d_in;
            r_w_out <= w_w_in;
          end
        end
      end else begin : g_chain
        logic [WIDTH-1:0] r_d_dly [gi];
        logic [WIDTH-1:0] r_w_dly [gi];

        always_ff @(posedge clock) begin
          if (reset || w_skew_clr) begin
            for (int j = 0; j < gi; j++) begin
              r_d_dly[j] <= '0;
              r_w_dly[j] <= '0;
            end
            r_d_out <= '0;
            r_w_out <= '0;
          end else begin
            r_d_dly[0] <= w_d_in;
            r_w_dly[0] <= w_w_in;
            for (int j = 1; j < gi; j++) begin
              r_d_dly[j] <= r_d_dly[j-1];
              r_w_dly[j] <= r_w_dly[j-1];
            end
            r_d_out <= r_d_dly[gi-1];
            r_w_out <= r_w_dly[gi-1];
          end
        end
      end

      assign bus.data_out[gi*WIDTH +: WIDTH]   = r_d_out;
      assign bus.weight_out[gi*WIDTH +: WIDTH] = r_w_out;
    end
  endgenerate

  assign bus.in_ready = (r_state == ST_STREAM);
  assign bus.pe_clear = (r_state == ST_CLEAR);
  assign bus.pe_load  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = (r_state == ST_DONE);

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Input sequencer for the N×N systolic multiply array built from PE tiles. It accepts one data row-vector and one weight column-vector per beat over a valid/ready handshake. It skews lane i by i cycles so operands reach the array as a diagonal wavefront, and drives the array-wide `clear` and `load` controls. After the last beat it flushes zeros until every product has been accumulated, then freezes the accumulators and pulses `done`.

## Interface
- `WIDTH`, default 32: element width, matching the PE `WIDTH`.
- `N`, default 4: array dimension, which is the number of lanes. Legal range is N ≥ 2.
- `KW`, default 16: width of the beat-count field `k_len`.

Ports:
- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a tile; honoured only in IDLE.
- `k_len`  in  KW  beats in the tile; sampled when `start` is honoured.
- `in_valid`  in  1  an upstream beat is present.
- `in_ready`  out  1  the feeder accepts a beat this cycle.
- `in_data`  in  N*WIDTH  data row; lane i occupies bits [i*WIDTH +: WIDTH].
- `in_weight`  in  N*WIDTH  weight column; same lane packing as `in_data`.
- `data_out`  out  N*WIDTH  skewed data; lane i drives PE row i `data_in`.
- `weight_out`  out  N*WIDTH  skewed weight; lane i drives PE column i `weight`.
- `pe_clear`  out  1  broadcast to the PE `clear` input.
- `pe_load`  out  1  broadcast to the PE `load` input (1 means hold).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the tile is complete.

## Operation
- **Beat acceptance:** a beat is accepted when `in_valid` and `in_ready` are both high in the same cycle.
- **Skew:** each lane has its own delay line. Lane i is delayed by i register stages, followed by a common output register.
  - The lane-i element of a beat accepted in cycle t appears on `data_out` and `weight_out` in cycle t+1+i.
- **Bubbles:** any cycle with no accepted beat loads zero into both the data and weight skew inputs. A zero operand contributes 0 to every accumulator, so bubbles never corrupt results.
- **States:**
  - IDLE:
    - outputs: `in_ready`=0, `pe_load`=1, `pe_clear`=0.
    - transition: on `start`, latch `k_len` and zero the beat counter, then go to CLEAR.
  - CLEAR:
    - lasts exactly 1 cycle.
    - outputs: `pe_clear`=1, `pe_load`=0; all skew registers are zeroed.
    - transition: go to DONE if the latched `k_len`==0, otherwise to STREAM.
  - STREAM:
    - outputs: `in_ready`=1, `pe_load`=0.
    - each accepted beat increments the counter.
    - transition: when the beat that makes the count equal `k_len` is accepted, go to FLUSH on the next cycle.
  - FLUSH:
    - lasts exactly 2N-1 cycles, tracked by a separate counter.
    - outputs: `in_ready`=0, `pe_load`=0; zeros are injected into the skew inputs.
    - transition: go to DONE.
  - DONE:
    - lasts 1 cycle.
    - outputs: `done`=1, `pe_load`=1.
    - transition: go to IDLE.
- **Ignored inputs:**
  - `start` outside IDLE is ignored; it is neither queued nor allowed to restart the tile.
  - `in_valid` outside STREAM is not accepted, because `in_ready`=0.
- **Width:** no arithmetic on the datapath; values pass through bit-exact. The beat counter is KW bits, so the maximum tile is 2^KW−1 beats.

## Timing
- **Reset values** (applied one cycle after `reset` is sampled high):
  - state IDLE;
  - `data_out`=0 and `weight_out`=0;
  - `in_ready`=0, `pe_clear`=0, `pe_load`=1, `busy`=0, `done`=0;
  - both counters 0.
- **Reset mid-operation:** takes priority over everything else. The tile is abandoned and no `done` pulse is produced.
- **Registered outputs:** `in_ready`, `pe_clear`, `pe_load`, `busy` and `done` are decoded combinationally from the registered state only. There is no combinational path from `in_valid` or `start` to any output.
- **Tile length:** with `start` sampled in cycle s and no bubbles, a tile takes the following cycles:
  - CLEAR in s+1;
  - STREAM in s+2 .. s+1+k;
  - FLUSH in s+2+k .. s+2N+k;
  - `done` in s+2N+1+k.
- **Bubbles:** each bubble extends STREAM by one cycle.
- **Flush sizing:** 2N-1 cycles covers N-1 cycles of skew plus N-1 PE-to-PE hops plus one accumulate cycle.

## Test plan
- **Reset values:** assert `reset` for 2 cycles in any state → next cycle shows all reset values above, including `pe_load`=1, `data_out`=0, `busy`=0.
- **Continuous tile:** N=4, `k_len`=3, `in_valid` held high, lane i of beat b = 16·b+i → timing is:
  - `pe_clear` high 1 cycle;
  - 3 beats accepted;
  - value 2 (beat 0, lane 2) on `data_out` lane 2 exactly 3 cycles after its acceptance;
  - FLUSH lasts 7 cycles;
  - `done` one cycle after FLUSH ends, 12 cycles after `start`.
- **Bubble:** `k_len`=2, `in_valid` low for one cycle between the two beats → all lanes carry 0 in that slot, the counter does not advance, and `done` arrives 1 cycle later than in the no-bubble case.
- **Empty tile:** `k_len`=0 → `pe_clear` pulse, then `done` on the next cycle; `in_ready` never rises.
- **Reset mid-stream:** `reset` after 1 of 3 beats → IDLE, skew outputs zero, no `done` pulse; a following `start` then runs a full tile normally.
- **Ignored inputs:** `start` pulsed during FLUSH, and `in_valid` high during IDLE → no restart, no beat accepted, and the `done` timing is unchanged.
